// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: default constants, FSM state encoding and PC helpers.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT   = 32'h0000_0013;
    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched instruction that decode could not yet accept.
module fetch_skid (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    // Clear wins so a flush in the same cycle never leaves a stale entry behind.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (i_clear) begin
            valid_d = 1'b0;
        end else if (i_load) begin
            valid_d = 1'b1;
            inst_d  = i_inst;
            pc_d    = i_pc;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            inst_q  <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_inst  = inst_q;
    assign o_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requests, IF/ID register, skid and redirect flush.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_ready
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_inst_q, if_inst_d;
    logic [31:0]  if_pc_q, if_pc_d;

    logic         skid_load, skid_clear;
    logic         skid_valid;
    logic [31:0]  skid_inst, skid_pc;
    logic         slot_free, resp_owed;

    fetch_skid u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (skid_load),
        .i_clear (skid_clear),
        .i_inst  (i_imem_rdata),
        .i_pc    (pc_q),
        .o_valid (skid_valid),
        .o_inst  (skid_inst),
        .o_pc    (skid_pc)
    );

    assign slot_free = !if_valid_q || i_ready;
    assign resp_owed = ((state_q == S_WAIT)  && !i_imem_rvalid) ||
                       ((state_q == S_REQ)   &&  i_imem_gnt)    ||
                       ((state_q == S_DRAIN) && !i_imem_rvalid);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        if (if_valid_q && i_ready) begin
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
        end

        unique case (state_q)
            S_REQ: begin
                if (i_imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    pc_d = next_pc(pc_q);
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = i_imem_rdata;
                        if_pc_d    = pc_q;
                        state_d    = S_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (i_ready) begin
                    if_valid_d = 1'b1;
                    if_inst_d  = skid_inst;
                    if_pc_d    = skid_pc;
                    skid_clear = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (i_imem_rvalid) state_d = S_REQ;
            end
        endcase

        // A redirect overrides everything; a response still in flight must be drained.
        if (i_redirect) begin
            pc_d       = align_pc(i_redirect_pc);
            if_valid_d = 1'b0;
            if_inst_d  = NOP_INST;
            skid_load  = 1'b0;
            skid_clear = 1'b1;
            state_d    = resp_owed ? S_DRAIN : S_REQ;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_ADDR;
            if_valid_q <= 1'b0;
            if_inst_q  <= NOP_INST;
            if_pc_q    <= RESET_ADDR;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign o_imem_req  = (state_q == S_REQ);
    assign o_imem_addr = pc_q;
    assign o_valid     = if_valid_q;
    assign o_inst      = if_inst_q;
    assign o_pc        = if_pc_q;

    a_no_stray_rvalid: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_imem_rvalid && (state_q == S_REQ || state_q == S_HOLD)));

    a_hold_has_skid: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == S_HOLD) |-> skid_valid);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage: the model is "decode must see PCs in order
// from the last reset/redirect target, each carrying mem(pc), with nothing lost or repeated".
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_valid;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_ready;

    int          checks;
    int          passed;
    int          consumed;
    int          c0;
    logic [63:0] expQ[$];
    logic [63:0] monEntry;
    logic [31:0] nextPc;
    logic [31:0] target;
    bit          expectFlush;
    bit          fired;
    bit          memBusy;
    int          memCnt;
    logic [31:0] memAddr;
    int          gntPct;
    int          latMax;

    fetch_stage #(.RESET_ADDR(RST_ADDR), .NOP_INST(NOP)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_valid       (o_valid),
        .o_inst        (o_inst),
        .o_pc          (o_pc),
        .i_ready       (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction memory contents are a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic refill();
        while (expQ.size() < 8) begin
            expQ.push_back({nextPc, memWord(nextPc)});
            nextPc = nextPc + 32'd4;
        end
    endtask

    // One cycle of stimulus at the falling edge: account for the rising edge just passed,
    // run the memory model, then choose ready/redirect. mode: 0 none, 1 always,
    // 2 only with rvalid, 3 only while a response is owed but not yet returned, else random.
    task automatic applyStimulus(input int readyPct, input int mode, input logic [31:0] tgt,
                                 output bit fire);
        bit waiting;
        @(negedge i_clk);
        if (i_redirect) begin
            expQ.delete();
            nextPc      = {i_redirect_pc[31:2], 2'b00};
            expectFlush = 1'b1;
        end
        if (i_imem_rvalid) begin
            i_imem_rvalid = 1'b0;
            memBusy       = 1'b0;
        end else if (memBusy) begin
            memCnt--;
            if (memCnt == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = memWord(memAddr);
            end
        end
        waiting    = memBusy && !i_imem_rvalid;
        i_imem_gnt = ($urandom_range(99) < gntPct);
        if (o_imem_req && i_imem_gnt) begin
            memBusy = 1'b1;
            memCnt  = $urandom_range(latMax, 1);
            memAddr = o_imem_addr;
        end
        i_ready = ($urandom_range(99) < readyPct);
        case (mode)
            0:       fire = 1'b0;
            1:       fire = 1'b1;
            2:       fire = i_imem_rvalid;
            3:       fire = waiting;
            default: fire = ($urandom_range(19) == 0);
        endcase
        i_redirect    = fire;
        i_redirect_pc = tgt;
        refill();
    endtask

    task automatic assertReset();
        @(negedge i_clk);
        i_rst         = 1'b1;
        i_redirect    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_gnt    = 1'b0;
        i_ready       = 1'b0;
        memBusy       = 1'b0;
        expectFlush   = 1'b0;
        expQ.delete();
        nextPc        = RST_ADDR;
        refill();
    endtask

    task automatic releaseReset(input int cycles);
        repeat (cycles) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // With gnt always given each request lasts one cycle, so each sighting is a new request.
    task automatic waitReqAddr(input string name, input logic [31:0] exp);
        bit found;
        bit f;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            applyStimulus(100, 0, 32'd0, f);
            if (o_imem_req) begin
                checkOutput(name, o_imem_addr, exp);
                found = 1'b1;
            end
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL %s: no request within 30 cycles, expected address %h", name, exp);
        end
    endtask

    // Monitor: just after each falling edge, any o_valid && i_ready is a transfer that the
    // next rising edge commits, so it is popped and compared against the reference stream.
    always begin
        @(negedge i_clk);
        #1;
        if (!i_rst) begin
            if (expectFlush) begin
                checkOutput("valid_after_redirect", {31'd0, o_valid}, 32'd0);
                expectFlush = 1'b0;
            end
            if (!o_valid) begin
                checkOutput("empty_slot_nop", o_inst, NOP);
            end else if (i_ready) begin
                consumed++;
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL scoreboard: unexpected instruction pc=%h inst=%h", o_pc, o_inst);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("decode_pc", o_pc, monEntry[63:32]);
                    checkOutput("decode_inst", o_inst, monEntry[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; passed = 0; consumed = 0;
        gntPct = 100; latMax = 1;
        i_rst = 1'b1; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'd0;
        i_redirect = 1'b0; i_redirect_pc = 32'd0; i_ready = 1'b0;
        memBusy = 1'b0; memCnt = 0; memAddr = 32'd0; expectFlush = 1'b0;
        nextPc = RST_ADDR;

        repeat (3) @(negedge i_clk);
        #1;
        checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("reset_inst", o_inst, NOP);
        checkOutput("reset_pc", o_pc, RST_ADDR);
        checkOutput("reset_req", {31'd0, o_imem_req}, 32'd1);
        checkOutput("reset_addr", o_imem_addr, RST_ADDR);

        // Streaming with immediate grant and 1-cycle latency: one instruction every 2 cycles.
        assertReset();
        releaseReset(1);
        repeat (4) applyStimulus(100, 0, 32'd0, fired);
        c0 = consumed;
        repeat (20) applyStimulus(100, 0, 32'd0, fired);
        checkOutput("throughput", 32'(consumed - c0), 32'd10);

        // Decode stall parks the next instruction in the skid and stops requests.
        repeat (6) applyStimulus(0, 0, 32'd0, fired);
        checkOutput("hold_no_req", {31'd0, o_imem_req}, 32'd0);
        checkOutput("hold_valid", {31'd0, o_valid}, 32'd1);
        repeat (10) applyStimulus(100, 0, 32'd0, fired);

        // Reset while holding clears IF/ID immediately and restarts at the reset address.
        repeat (6) applyStimulus(0, 0, 32'd0, fired);
        checkOutput("hold_no_req2", {31'd0, o_imem_req}, 32'd0);
        assertReset();
        #2;
        checkOutput("midreset_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("midreset_inst", o_inst, NOP);
        checkOutput("midreset_pc", o_pc, RST_ADDR);
        checkOutput("midreset_addr", o_imem_addr, RST_ADDR);
        releaseReset(2);
        repeat (12) applyStimulus(100, 0, 32'd0, fired);

        // Redirect while a response is owed: drain it, then fetch the target.
        latMax = 3;
        fired = 1'b0;
        for (int k = 0; k < 50 && !fired; k++) applyStimulus(100, 3, 32'h0000_0100, fired);
        if (!fired) begin
            checks++;
            $display("[TB] FAIL redirect_wait: no waiting cycle found, got none, required one");
        end
        applyStimulus(100, 0, 32'd0, fired);
        checkOutput("drain_no_req", {31'd0, o_imem_req}, 32'd0);
        waitReqAddr("redirect_target", 32'h0000_0100);
        repeat (10) applyStimulus(100, 0, 32'd0, fired);

        // Redirect coinciding with rvalid: no drain, unaligned target is rounded down.
        fired = 1'b0;
        for (int k = 0; k < 50 && !fired; k++) applyStimulus(100, 2, 32'h0000_0203, fired);
        if (!fired) begin
            checks++;
            $display("[TB] FAIL redirect_rvalid: no rvalid cycle found, got none, required one");
        end
        applyStimulus(100, 0, 32'd0, fired);
        checkOutput("redirect_rvalid_req", {31'd0, o_imem_req}, 32'd1);
        checkOutput("redirect_rvalid_addr", o_imem_addr, 32'h0000_0200);
        repeat (10) applyStimulus(100, 0, 32'd0, fired);

        // PC wraps modulo 2^32.
        applyStimulus(100, 1, 32'hFFFF_FFFC, fired);
        waitReqAddr("wrap_first", 32'hFFFF_FFFC);
        waitReqAddr("wrap_next", 32'h0000_0000);
        repeat (10) applyStimulus(100, 0, 32'd0, fired);

        // Random traffic: grant, latency, back-pressure and redirects all vary.
        gntPct = 60;
        for (int n = 0; n < 1500; n++) begin
            target = $urandom;
            if ($urandom_range(3) == 0) target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            applyStimulus(70, 4, target, fired);
        end
        applyStimulus(100, 0, 32'd0, fired);
        repeat (4) applyStimulus(100, 0, 32'd0, fired);
        checkOutput("progress", {31'd0, consumed > 100}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
